// File: rtl/l2_l1_msg_scheduler_pkg.sv
// Shared definitions for the L2-to-L1 message path: address width,
// message encoding and the legality check used by the scheduler.
package l2_l1_msg_scheduler_pkg;

    localparam int ADDRESS_SIZE = 32;

    typedef enum logic [2:0] {
        MSG_NONE       = 3'd0,
        GETLINE        = 3'd1,
        SENDLINE       = 3'd2,
        INVALIDATELINE = 3'd3,
        EVICTLINE      = 3'd4
    } l2_to_l1_e;

    // Codes GETLINE..EVICTLINE are deliverable; everything else is dropped.
    function automatic logic legal_msg(input logic [2:0] code);
        return (code >= GETLINE) && (code <= EVICTLINE);
    endfunction

endpackage

// File: rtl/l2_l1_msg_scheduler_msg_fifo.sv
// Generic synchronous FIFO. The head entry is read straight from the
// storage array, so the output only changes on a clock edge or on reset.
// DEPTH must be a power of two so the pointers wrap naturally.
module msg_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Qualify requests so an overflow or underflow can never corrupt state.
    always_comb begin
        full     = (count == FULL_COUNT);
        empty    = (count == '0);
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        pop_data = mem[rd_ptr];
    end

    // Storage, pointers and occupancy; reset clears everything so the head reads 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/l2_l1_msg_scheduler.sv
// Arbitrates L2-side message sources (snoop path S, processor path P)
// into a small FIFO feeding the L1 consumer. S has priority, but P is
// forced through after STARVE_LIMIT consecutive lost cycles. Illegal
// codes are accepted, dropped, and flagged on err_illegal.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high; ready may depend on valid, valid must not depend on ready.
module l2_l1_msg_scheduler
    import l2_l1_msg_scheduler_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [2:0]                    s_msg,
    input  logic [ADDRESS_SIZE-1:0]       s_addr,
    input  logic                          p_valid,
    output logic                          p_ready,
    input  logic [2:0]                    p_msg,
    input  logic [ADDRESS_SIZE-1:0]       p_addr,
    output logic                          l1_valid,
    input  logic                          l1_ready,
    output logic [2:0]                    l1_msg,
    output logic [ADDRESS_SIZE-1:0]       l1_addr,
    output logic [$clog2(FIFO_DEPTH):0]   pending,
    output logic                          err_illegal
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int MW = 3 + ADDRESS_SIZE;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [SW-1:0]           starve;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    p_force;
    logic                    grant_s;
    logic                    grant_p;
    logic                    accept;
    logic                    push;
    logic                    pop;
    logic [2:0]              sel_msg;
    logic [ADDRESS_SIZE-1:0] sel_addr;
    logic [MW-1:0]           head;

    // Grant selection: nothing while in reset or full (no pass-through on a pop).
    always_comb begin
        p_force = p_valid && (starve == STARVE_MAX);
        grant_s = 1'b0;
        grant_p = 1'b0;
        if (rst_n && !fifo_full) begin
            if (p_force) begin
                grant_p = 1'b1;
            end else if (s_valid) begin
                grant_s = 1'b1;
            end else if (p_valid) begin
                grant_p = 1'b1;
            end
        end
        s_ready  = grant_s;
        p_ready  = grant_p;
        accept   = grant_s | grant_p;
        sel_msg  = grant_p ? p_msg  : s_msg;
        sel_addr = grant_p ? p_addr : s_addr;
        push     = accept & legal_msg(sel_msg);
        pop      = l1_valid & l1_ready;
        l1_valid = ~fifo_empty;
        l1_msg   = head[MW-1:ADDRESS_SIZE];
        l1_addr  = head[ADDRESS_SIZE-1:0];
    end

    // Count cycles in which a waiting P loses to S; frozen while the FIFO is full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve <= '0;
        end else if (!p_valid || grant_p) begin
            starve <= '0;
        end else if (!fifo_full && (starve != STARVE_MAX)) begin
            starve <= starve + 1'b1;
        end
    end

    // One-cycle flag for an accepted-but-dropped illegal code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_illegal <= 1'b0;
        end else begin
            err_illegal <= accept & ~legal_msg(sel_msg);
        end
    end

    msg_fifo #(
        .WIDTH (MW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({sel_msg, sel_addr}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (pending)
    );

endmodule

// File: tb/tb_l2_l1_msg_scheduler.sv
// Directed bench for l2_l1_msg_scheduler: reset, single delivery,
// starvation pattern, full FIFO back-pressure, illegal codes, stalled L1
// and asynchronous flush. Deliveries are checked against exp_q in order.
module tb_l2_l1_msg_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid, p_valid, l1_ready;
    logic        s_ready, p_ready, l1_valid, err_illegal;
    logic [2:0]  s_msg, p_msg, l1_msg;
    logic [31:0] s_addr, p_addr, l1_addr;
    logic [2:0]  pending;

    int checks = 0;
    int errors = 0;
    logic [34:0] exp_q[$];

    l2_l1_msg_scheduler #(.FIFO_DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_msg       (s_msg),
        .s_addr      (s_addr),
        .p_valid     (p_valid),
        .p_ready     (p_ready),
        .p_msg       (p_msg),
        .p_addr      (p_addr),
        .l1_valid    (l1_valid),
        .l1_ready    (l1_ready),
        .l1_msg      (l1_msg),
        .l1_addr     (l1_addr),
        .pending     (pending),
        .err_illegal (err_illegal)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_s(input logic v, input logic [2:0] m, input logic [31:0] a);
        s_valid = v;
        s_msg   = m;
        s_addr  = a;
    endtask

    task automatic drive_p(input logic v, input logic [2:0] m, input logic [31:0] a);
        p_valid = v;
        p_msg   = m;
        p_addr  = a;
    endtask

    // Scoreboard: every L1 transfer must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && l1_valid === 1'b1 && l1_ready === 1'b1) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL l1_spurious observed=0x%0h expected=none", {l1_msg, l1_addr});
            end
            if (exp_q.size() > 0) begin
                chk("l1_deliver", {29'd0, l1_msg, l1_addr}, {29'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        // Reset state, with S valid to prove readies are held low in reset
        rst_n    = 1'b0;
        l1_ready = 1'b0;
        drive_s(1'b1, 3'd1, 32'h0000_1000);
        drive_p(1'b0, 3'd0, 32'h0);
        #2;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_p_ready", p_ready, 0);
        chk("rst_l1_valid", l1_valid, 0);
        chk("rst_l1_msg", l1_msg, 0);
        chk("rst_l1_addr", l1_addr, 0);
        chk("rst_pending", pending, 0);
        chk("rst_err", err_illegal, 0);
        drive_s(1'b0, 3'd0, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // Single GETLINE from S, L1 always ready
        l1_ready = 1'b1;
        drive_s(1'b1, 3'd1, 32'h0000_1000);
        #1;
        chk("t1_s_ready", s_ready, 1);
        chk("t1_p_ready", p_ready, 0);
        exp_q.push_back({3'd1, 32'h0000_1000});
        tick();
        drive_s(1'b0, 3'd0, 32'h0);
        #1;
        chk("t1_l1_valid", l1_valid, 1);
        chk("t1_l1_msg", l1_msg, 1);
        chk("t1_l1_addr", l1_addr, 32'h0000_1000);
        chk("t1_pending", pending, 1);
        tick();
        chk("t1_pending_drained", pending, 0);
        chk("t1_l1_valid_low", l1_valid, 0);

        // Both valid continuously: S,S,S,P repeating
        for (int i = 0; i < 8; i++) begin
            drive_s(1'b1, 3'd2, 32'h100 + i);
            drive_p(1'b1, 3'd3, 32'h200 + i);
            #1;
            if (i % 4 == 3) begin
                chk($sformatf("t2_p_ready_%0d", i), p_ready, 1);
                chk($sformatf("t2_s_ready_%0d", i), s_ready, 0);
                exp_q.push_back({3'd3, 32'h200 + i});
            end else begin
                chk($sformatf("t2_s_ready_%0d", i), s_ready, 1);
                chk($sformatf("t2_p_ready_%0d", i), p_ready, 0);
                exp_q.push_back({3'd2, 32'h100 + i});
            end
            if (i > 0) begin
                chk($sformatf("t2_pending_%0d", i), pending, 1);
            end
            tick();
        end
        drive_s(1'b0, 3'd0, 32'h0);
        drive_p(1'b0, 3'd0, 32'h0);
        tick();
        chk("t2_pending_drained", pending, 0);

        // Fill the FIFO with L1 stalled, then drain in order
        l1_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_s(1'b1, 3'(i + 1), 32'h3000 + 4 * i);
            #1;
            chk($sformatf("t3_s_ready_%0d", i), s_ready, 1);
            exp_q.push_back({3'(i + 1), 32'h3000 + 4 * i});
            tick();
        end
        drive_s(1'b1, 3'd1, 32'h3010);
        #1;
        chk("t3_full_s_ready", s_ready, 0);
        chk("t3_full_pending", pending, 4);
        chk("t3_head_msg", l1_msg, 1);
        chk("t3_head_addr", l1_addr, 32'h3000);
        l1_ready = 1'b1;
        #1;
        chk("t3_no_passthrough", s_ready, 0);
        tick();
        chk("t3_reassert_s_ready", s_ready, 1);
        chk("t3_pending_after_pop", pending, 3);
        exp_q.push_back({3'd1, 32'h3010});
        tick();
        chk("t3_pending_push_pop", pending, 3);
        drive_s(1'b0, 3'd0, 32'h0);
        for (int i = 0; i < 6; i++) tick();
        chk("t3_pending_drained", pending, 0);

        // Illegal codes from P are consumed and flagged, never delivered
        drive_p(1'b1, 3'd0, 32'h2000);
        #1;
        chk("t4_p_ready_code0", p_ready, 1);
        tick();
        chk("t4_err_code0", err_illegal, 1);
        chk("t4_pending_code0", pending, 0);
        drive_p(1'b1, 3'd6, 32'h2020);
        #1;
        chk("t4_p_ready_code6", p_ready, 1);
        tick();
        chk("t4_err_code6", err_illegal, 1);
        chk("t4_l1_valid_code6", l1_valid, 0);
        drive_p(1'b1, 3'd4, 32'h0000_2040);
        exp_q.push_back({3'd4, 32'h0000_2040});
        tick();
        drive_p(1'b0, 3'd0, 32'h0);
        chk("t4_err_clear", err_illegal, 0);
        chk("t4_pending_evict", pending, 1);
        chk("t4_l1_msg_evict", l1_msg, 4);
        chk("t4_l1_addr_evict", l1_addr, 32'h0000_2040);
        tick();
        chk("t4_pending_drained", pending, 0);
        chk("t4_err_low", err_illegal, 0);

        // Three queued messages, L1 ready toggling: head holds during stalls
        l1_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_s(1'b1, 3'(i + 1), 32'h5000 + 4 * i);
            exp_q.push_back({3'(i + 1), 32'h5000 + 4 * i});
            tick();
        end
        drive_s(1'b0, 3'd0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            l1_ready = (i % 2 == 1);
            #1;
            if (!l1_ready) begin
                chk($sformatf("t5_stall_valid_%0d", i), l1_valid, 1);
                chk($sformatf("t5_stall_msg_%0d", i), l1_msg, exp_q[0][34:32]);
                chk($sformatf("t5_stall_addr_%0d", i), l1_addr, exp_q[0][31:0]);
                chk($sformatf("t5_stall_pending_%0d", i), pending, exp_q.size());
            end
            tick();
        end
        chk("t5_pending_drained", pending, 0);

        // Asynchronous flush with 3 queued, then fresh traffic
        l1_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_s(1'b1, 3'd3, 32'h6100 + 4 * i);
            exp_q.push_back({3'd3, 32'h6100 + 4 * i});
            tick();
        end
        chk("t6_pending_before_flush", pending, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_flush_l1_valid", l1_valid, 0);
        chk("t6_flush_pending", pending, 0);
        chk("t6_flush_l1_addr", l1_addr, 0);
        chk("t6_flush_s_ready", s_ready, 0);
        exp_q.delete();
        drive_s(1'b0, 3'd0, 32'h0);
        tick();
        rst_n    = 1'b1;
        l1_ready = 1'b1;
        drive_s(1'b1, 3'd2, 32'h6000);
        exp_q.push_back({3'd2, 32'h6000});
        tick();
        drive_s(1'b0, 3'd0, 32'h0);
        chk("t6_first_valid", l1_valid, 1);
        chk("t6_first_msg", l1_msg, 2);
        chk("t6_first_addr", l1_addr, 32'h6000);
        tick();
        chk("t6_pending_drained", pending, 0);
        chk("final_exp_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
